hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NFWD, default 2: number of forwarding stages after E (stage 1 closest to E).
REQ-002 SHALL have parameter REGW, default 5: register index width; NREG = 2**REGW.
REQ-003 SHALL have parameter MAXOUT, default 4, range 1..15: maximum outstanding long-latency writes.
REQ-004 SHALL have parameter CNTW, default 16: stall counter width.
REQ-005 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port RESET_N  input  1  asynchronous active-low reset.
REQ-007 SHALL have ports RS_E, RT_E  input  REGW  source registers of the E-stage instruction.
REQ-008 SHALL have port FWD_DST  input  NFWD*REGW  destination register per stage; stage k occupies bits [k*REGW-1:(k-1)*REGW].
REQ-009 SHALL have port FWD_WE  input  NFWD  stage k writes the register file.
REQ-010 SHALL have port FWD_RDY  input  NFWD  stage k result is valid for forwarding (0 for load data not yet returned).
REQ-011 SHALL have ports ISSUE_LONG, ISSUE_DST  input  1, REGW  E-stage instruction starts a long-latency op (mul/div/load-miss) targeting ISSUE_DST.
REQ-012 SHALL have ports LONG_DONE, LONG_DST  input  1, REGW  long-latency op completes and writes LONG_DST this cycle.
REQ-013 SHALL have port FLUSH_E  input  1  E-stage instruction is killed.
REQ-014 SHALL have ports FWD_SEL_A, FWD_SEL_B  output  $clog2(NFWD+1)  0 = register file, k = stage k.
REQ-015 SHALL have port STALL_FDE  output  1  hold F, D, E.
REQ-016 SHALL have port BUBBLE_M  output  1  insert NOP into stage 1.
REQ-017 SHALL have ports OUTSTANDING  output  $clog2(MAXOUT+1)  and  STALL_CNT  output  CNTW.
REQ-018 SHALL have port ERR  output  1  sticky protocol error.

Function
REQ-019 FWD_SEL_A SHALL be the smallest k with RS_E!=0, FWD_WE[k], FWD_DST[k]==RS_E; else 0. Same for FWD_SEL_B with RT_E. Combinational.
REQ-020 A data stall SHALL be raised when a matched source's selected stage k has FWD_RDY[k]==0 (register 0 never matches).
REQ-021 Scoreboard: NREG-bit PENDING register; bit 0 SHALL be constant 0.
REQ-022 A scoreboard stall SHALL be raised when PENDING[RS_E] or PENDING[RT_E] is set, unless LONG_DONE with LONG_DST equal to that register this cycle (same-cycle bypass).
REQ-023 An issue stall SHALL be raised when ISSUE_LONG and (OUTSTANDING==MAXOUT without a LONG_DONE this cycle, or PENDING[ISSUE_DST] set without same-cycle LONG_DONE to it -- WAW).
REQ-024 STALL_FDE SHALL equal OR of data, scoreboard and issue stalls, gated off by FLUSH_E; BUBBLE_M SHALL equal STALL_FDE.
REQ-025 Accepted issue = ISSUE_LONG & ~STALL_FDE & ~FLUSH_E & ISSUE_DST!=0; on next edge SHALL set PENDING[ISSUE_DST] and increment OUTSTANDING.
REQ-026 LONG_DONE with PENDING[LONG_DST] set SHALL clear the bit and decrement OUTSTANDING.
REQ-027 Issue and done on the same register in one cycle: bit SHALL stay set, OUTSTANDING unchanged; on different registers: both applied, OUTSTANDING unchanged.
REQ-028 LONG_DONE to a non-pending register, or LONG_DST==0, SHALL set ERR and leave PENDING/OUTSTANDING unchanged.
REQ-029 STALL_CNT SHALL increment each cycle STALL_FDE==1, saturating at all-ones.
REQ-030 ERR SHALL remain set until reset.

Reset
REQ-031 RESET_N low SHALL asynchronously clear PENDING, OUTSTANDING, STALL_CNT, ERR; combinational outputs follow inputs and cleared state.
REQ-032 Reset mid-operation SHALL drop all outstanding entries; a later LONG_DONE for a dropped entry SHALL set ERR.
REQ-033 While RESET_N low no state SHALL update on CLK.

Verification
REQ-034 FWD_WE=2'b11, FWD_DST={5,5}, RS_E=5, RDY=2'b11 -> FWD_SEL_A=1, no stall; RS_E=0, same inputs -> FWD_SEL_A=0.
REQ-035 Load at stage 1 (DST=7, WE=1, RDY[1]=0), RT_E=7 -> STALL_FDE=1, BUBBLE_M=1, STALL_CNT +1 per cycle; RDY[1]=1 -> stall drops, FWD_SEL_B=1.
REQ-036 Issue long to r9, next cycle RS_E=9 -> stall; cycle with LONG_DONE/LONG_DST=9 -> no stall that cycle, PENDING[9]=0, OUTSTANDING=0 after edge.
REQ-037 MAXOUT=4: issue r1..r4, then issue r5 -> stall, OUTSTANDING=4; LONG_DONE r2 same cycle -> issue accepted, OUTSTANDING stays 4.
REQ-038 LONG_DONE r12 while nothing pending -> ERR=1, OUTSTANDING=0; assert RESET_N low mid-sequence with 3 outstanding -> all counters, PENDING, ERR zero immediately.
REQ-039 STALL_CNT preset near max (CNTW=4, 15 stall cycles) -> holds 15 on further stalls.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// E-stage hazard unit: forwarding-source select, load-use and long-latency
// scoreboard stalls, outstanding-write tracking, stall counter and sticky error flag.
module hazard_scoreboard #(
  parameter int NFWD   = 2,
  parameter int REGW   = 5,
  parameter int MAXOUT = 4,
  parameter int CNTW   = 16
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic [REGW-1:0]               RS_E,
  input  logic [REGW-1:0]               RT_E,
  input  logic [NFWD*REGW-1:0]          FWD_DST,
  input  logic [NFWD-1:0]               FWD_WE,
  input  logic [NFWD-1:0]               FWD_RDY,
  input  logic                          ISSUE_LONG,
  input  logic [REGW-1:0]               ISSUE_DST,
  input  logic                          LONG_DONE,
  input  logic [REGW-1:0]               LONG_DST,
  input  logic                          FLUSH_E,
  output logic [$clog2(NFWD+1)-1:0]     FWD_SEL_A,
  output logic [$clog2(NFWD+1)-1:0]     FWD_SEL_B,
  output logic                          STALL_FDE,
  output logic                          BUBBLE_M,
  output logic [$clog2(MAXOUT+1)-1:0]   OUTSTANDING,
  output logic [CNTW-1:0]               STALL_CNT,
  output logic                          ERR
);

  localparam int NREG = 2 ** REGW;
  localparam int SELW = $clog2(NFWD + 1);
  localparam int OUTW = $clog2(MAXOUT + 1);

  logic [NREG-1:0] pending_r;
  logic [NREG-1:0] pending_nxt_s;
  logic [OUTW-1:0] outstanding_r;
  logic [CNTW-1:0] stall_cnt_r;
  logic            err_r;
  logic [SELW-1:0] sel_a_s;
  logic [SELW-1:0] sel_b_s;
  logic            data_stall_s;
  logic            sb_stall_s;
  logic            issue_stall_s;
  logic            stall_s;
  logic            done_ok_s;
  logic            accept_s;
  logic            full_s;

  // Youngest matching writer wins; register 0 never forwards.
  function automatic logic [SELW-1:0] fwd_sel(input logic [REGW-1:0] src,
                                              input logic [NFWD*REGW-1:0] dst,
                                              input logic [NFWD-1:0] we);
    logic [SELW-1:0] sel;
    sel = {SELW{1'b0}};
    for (int k = NFWD; k >= 1; k--) begin
      if ((src != {REGW{1'b0}}) && we[k-1] && (dst[(k-1)*REGW +: REGW] == src)) begin
        sel = SELW'(k);
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  function automatic logic sel_not_ready(input logic [SELW-1:0] sel,
                                         input logic [NFWD-1:0] rdy);
    logic nr;
    nr = 1'b0;
    for (int k = 1; k <= NFWD; k++) begin
      if ((sel == SELW'(k)) && !rdy[k-1]) begin
        nr = 1'b1;
      end else begin
        nr = nr;
      end
    end
    return nr;
  endfunction

  // A completion only counts when it retires a genuinely pending register.
  assign done_ok_s = LONG_DONE && (LONG_DST != {REGW{1'b0}}) && pending_r[LONG_DST];
  assign full_s    = (outstanding_r == OUTW'(MAXOUT));

  // Hazard detection for the E-stage instruction.
  always_comb begin
    sel_a_s       = fwd_sel(RS_E, FWD_DST, FWD_WE);
    sel_b_s       = fwd_sel(RT_E, FWD_DST, FWD_WE);
    data_stall_s  = sel_not_ready(sel_a_s, FWD_RDY) || sel_not_ready(sel_b_s, FWD_RDY);
    sb_stall_s    = (pending_r[RS_E] && !(done_ok_s && (LONG_DST == RS_E))) ||
                    (pending_r[RT_E] && !(done_ok_s && (LONG_DST == RT_E)));
    issue_stall_s = ISSUE_LONG &&
                    ((full_s && !done_ok_s) ||
                     (pending_r[ISSUE_DST] && !(done_ok_s && (LONG_DST == ISSUE_DST))));
    stall_s       = (data_stall_s || sb_stall_s || issue_stall_s) && !FLUSH_E;
    accept_s      = ISSUE_LONG && !stall_s && !FLUSH_E && (ISSUE_DST != {REGW{1'b0}});
  end

  // Retire before issue so a same-register issue/done pair leaves the bit set.
  always_comb begin
    pending_nxt_s = pending_r;
    if (done_ok_s) begin
      pending_nxt_s[LONG_DST] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (accept_s) begin
      pending_nxt_s[ISSUE_DST] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Scoreboard, outstanding count, stall counter and sticky error state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending_r     <= {NREG{1'b0}};
      outstanding_r <= {OUTW{1'b0}};
      stall_cnt_r   <= {CNTW{1'b0}};
      err_r         <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      case ({accept_s, done_ok_s})
        2'b10:   outstanding_r <= outstanding_r + OUTW'(1'b1);
        2'b01:   outstanding_r <= outstanding_r - OUTW'(1'b1);
        default: outstanding_r <= outstanding_r;
      endcase
      if (stall_s && (stall_cnt_r != {CNTW{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNTW'(1'b1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (LONG_DONE && !done_ok_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign FWD_SEL_A   = sel_a_s;
  assign FWD_SEL_B   = sel_b_s;
  assign STALL_FDE   = stall_s;
  assign BUBBLE_M    = stall_s;
  assign OUTSTANDING = outstanding_r;
  assign STALL_CNT   = stall_cnt_r;
  assign ERR         = err_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized + directed bench for hazard_scoreboard: a set-based reference model
// queues expected outputs per cycle and a negedge monitor compares them.
module tb_hazard_scoreboard;

  localparam int NFWD   = 2;
  localparam int REGW   = 5;
  localparam int MAXOUT = 4;
  localparam int CNTW   = 4;
  localparam int NREG   = 32;
  localparam int CMAX   = 15;

  logic                 CLK = 1'b0;
  logic                 RESET_N;
  logic [REGW-1:0]      RS_E, RT_E, ISSUE_DST, LONG_DST;
  logic [NFWD*REGW-1:0] FWD_DST;
  logic [NFWD-1:0]      FWD_WE, FWD_RDY;
  logic                 ISSUE_LONG, LONG_DONE, FLUSH_E;
  logic [1:0]           FWD_SEL_A, FWD_SEL_B;
  logic                 STALL_FDE, BUBBLE_M, ERR;
  logic [2:0]           OUTSTANDING;
  logic [CNTW-1:0]      STALL_CNT;

  always #5 CLK = ~CLK;

  hazard_scoreboard #(.NFWD(NFWD), .REGW(REGW), .MAXOUT(MAXOUT), .CNTW(CNTW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .RS_E(RS_E), .RT_E(RT_E), .FWD_DST(FWD_DST),
    .FWD_WE(FWD_WE), .FWD_RDY(FWD_RDY), .ISSUE_LONG(ISSUE_LONG), .ISSUE_DST(ISSUE_DST),
    .LONG_DONE(LONG_DONE), .LONG_DST(LONG_DST), .FLUSH_E(FLUSH_E),
    .FWD_SEL_A(FWD_SEL_A), .FWD_SEL_B(FWD_SEL_B), .STALL_FDE(STALL_FDE),
    .BUBBLE_M(BUBBLE_M), .OUTSTANDING(OUTSTANDING), .STALL_CNT(STALL_CNT), .ERR(ERR)
  );

  typedef struct {
    int sel_a; int sel_b; int stall; int bubble; int outst; int cnt; int err;
  } exp_t;

  exp_t q[$];
  bit   pend[NREG];
  int   m_cnt;
  bit   m_err;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int m_sel(input logic [REGW-1:0] src);
    for (int k = 1; k <= NFWD; k++)
      if (src != 0 && FWD_WE[k-1] && FWD_DST[(k-1)*REGW +: REGW] == src) return k;
    return 0;
  endfunction

  function automatic int npend();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += int'(pend[i]);
    return n;
  endfunction

  // Model one cycle: queue expected outputs, then apply the edge's effect.
  task automatic tick();
    exp_t e;
    int sa, sb, outs;
    bit ds, sbs, iss, stall, ok, acc;
    if (!RESET_N) begin
      for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
      m_cnt = 0;
      m_err = 1'b0;
    end
    outs = npend();
    sa = m_sel(RS_E);
    sb = m_sel(RT_E);
    ds = (sa != 0 && !FWD_RDY[sa-1]) || (sb != 0 && !FWD_RDY[sb-1]);
    ok = LONG_DONE && LONG_DST != 0 && pend[LONG_DST];
    sbs = (pend[RS_E] && !(ok && LONG_DST == RS_E)) || (pend[RT_E] && !(ok && LONG_DST == RT_E));
    iss = ISSUE_LONG && ((outs == MAXOUT && !ok) || (pend[ISSUE_DST] && !(ok && LONG_DST == ISSUE_DST)));
    stall = (ds || sbs || iss) && !FLUSH_E;
    e = '{sa, sb, int'(stall), int'(stall), outs, m_cnt, int'(m_err)};
    q.push_back(e);
    if (RESET_N) begin
      acc = ISSUE_LONG && !stall && !FLUSH_E && ISSUE_DST != 0;
      if (LONG_DONE && !ok) m_err = 1'b1;
      if (ok) pend[LONG_DST] = 1'b0;
      if (acc) pend[ISSUE_DST] = 1'b1;
      if (stall && m_cnt < CMAX) m_cnt++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RS_E = 0; RT_E = 0; FWD_DST = 0; FWD_WE = 0; FWD_RDY = 2'b11;
    ISSUE_LONG = 0; ISSUE_DST = 0; LONG_DONE = 0; LONG_DST = 0; FLUSH_E = 0;
  endtask

  task automatic issue(input int r);
    idle(); ISSUE_LONG = 1; ISSUE_DST = REGW'(r); tick();
  endtask

  task automatic done(input int r);
    idle(); LONG_DONE = 1; LONG_DST = REGW'(r); tick();
  endtask

  // Monitor: compare every presented output against the oldest expectation.
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("fwd_sel_a",   32'(FWD_SEL_A),   e.sel_a);
      chk("fwd_sel_b",   32'(FWD_SEL_B),   e.sel_b);
      chk("stall_fde",   32'(STALL_FDE),   e.stall);
      chk("bubble_m",    32'(BUBBLE_M),    e.bubble);
      chk("outstanding", 32'(OUTSTANDING), e.outst);
      chk("stall_cnt",   32'(STALL_CNT),   e.cnt);
      chk("err",         32'(ERR),         e.err);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int plist[$];
    idle();
    RESET_N = 1'b0;
    @(posedge CLK); #1;
    tick(); tick();
    RESET_N = 1'b1;
    tick();

    // Forwarding from stage 1 when both stages match; r0 never forwards.
    idle(); FWD_WE = 2'b11; FWD_DST = {5'd5, 5'd5}; RS_E = 5; tick();
    RS_E = 0; tick();
    idle(); FWD_WE = 2'b10; FWD_DST = {5'd6, 5'd3}; RS_E = 6; RT_E = 3; tick();

    // Load-use stall until data returns.
    idle(); FWD_DST = {5'd0, 5'd7}; FWD_WE = 2'b01; FWD_RDY = 2'b10; RT_E = 7;
    tick(); tick(); tick();
    FWD_RDY = 2'b11; tick();

    // Long op to r9 with same-cycle completion bypass.
    issue(9);
    idle(); RS_E = 9; tick();
    idle(); RS_E = 9; LONG_DONE = 1; LONG_DST = 9; tick();
    idle(); tick();

    // Fill to MAXOUT, blocked issue, then issue alongside a completion.
    issue(1); issue(2); issue(3); issue(4);
    issue(5);
    idle(); ISSUE_LONG = 1; ISSUE_DST = 5; LONG_DONE = 1; LONG_DST = 2; tick();
    idle(); ISSUE_LONG = 1; ISSUE_DST = 3; LONG_DONE = 1; LONG_DST = 3; tick();
    issue(4);
    done(1); done(3); done(4); done(5);
    idle(); tick();

    // Spurious completion, then reset with entries in flight.
    done(12);
    issue(1); issue(2); issue(3);
    idle(); RESET_N = 1'b0; tick();
    RESET_N = 1'b1; tick();
    done(1);
    done(0);

    // Stall counter saturation.
    RESET_N = 1'b0; idle(); tick();
    RESET_N = 1'b1;
    idle(); FWD_DST = {5'd0, 5'd4}; FWD_WE = 2'b01; FWD_RDY = 2'b10; RS_E = 4;
    repeat (18) tick();
    FLUSH_E = 1; tick();

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      RESET_N    = ($urandom_range(0, 149) != 0);
      RS_E       = REGW'($urandom_range(0, 7));
      RT_E       = REGW'($urandom_range(0, 7));
      FWD_DST    = {REGW'($urandom_range(0, 7)), REGW'($urandom_range(0, 7))};
      FWD_WE     = NFWD'($urandom_range(0, 3));
      FWD_RDY    = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      ISSUE_LONG = ($urandom_range(0, 9) < 3);
      ISSUE_DST  = REGW'($urandom_range(0, 7));
      FLUSH_E    = ($urandom_range(0, 9) == 0);
      LONG_DONE  = ($urandom_range(0, 9) < 3);
      plist = {};
      for (int i = 1; i < NREG; i++) if (pend[i]) plist.push_back(i);
      if (plist.size() > 0 && $urandom_range(0, 49) != 0)
        LONG_DST = REGW'(plist[$urandom_range(0, plist.size() - 1)]);
      else
        LONG_DST = REGW'($urandom_range(0, 7));
      tick();
    end

    RESET_N = 1'b1;
    idle(); tick();
    repeat (3) @(negedge CLK);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d queued entries expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
